// File: rtl/laneswitch_pkg.sv
// Shared types for the lane switch ownership controller: FSM state encoding
// and the lane select encoding driven onto the lane switch.
package laneswitch_pkg;

    typedef enum logic [2:0] {
        OWN0   = 3'd0,
        OWN1   = 3'd1,
        DRAIN  = 3'd2,
        FLIP   = 3'd3,
        SETTLE = 3'd4,
        ERROR  = 3'd5
    } ls_state_t;

    localparam logic LS_LANE0 = 1'b0;
    localparam logic LS_LANE1 = 1'b1;

endpackage

// File: rtl/laneswitch_idle_cnt.sv
// Saturating counter of consecutive idle cycles of the lane switch; done marks
// the cycle that completes DRAIN_CYCLES idle cycles in a row.
module laneswitch_idle_cnt #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic active,
    output logic done
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

    logic [CW-1:0] idle_q;

    // Cleared outside the drain window so every drain starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else if (!en || active) begin
            idle_q <= '0;
        end else if (idle_q != LAST) begin
            idle_q <= idle_q + CW'(1);
        end
    end

    assign done = en && !active && (idle_q == LAST);

endmodule

// File: rtl/laneswitch_ctrl.sv
// Ping-pong ownership controller for the two-lane memory lane switch.
// Define LANESWITCH_CTRL_TIMEOUT_EN to build the drain watchdog.
module laneswitch_ctrl
    import laneswitch_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lane0_done,
    input  logic                   lane1_done,
    input  logic                   active,
    input  logic                   fault,
    output logic                   switch,
    output logic                   lane0_grant,
    output logic                   lane1_grant,
    output logic                   busy,
    output logic                   error,
    output logic                   timeout,
    output logic [COUNT_WIDTH-1:0] swap_count,
    output ls_state_t              dbg_state
);

    // Out-of-range drain lengths fall back to the nearest usable value.
    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 :
                               (DRAIN_CYCLES > TIMEOUT_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;

    ls_state_t state_q, state_d;
    logic      drain_done;
    logic      wd_expired;

    laneswitch_idle_cnt #(
        .DRAIN_CYCLES(DRAIN_EFF)
    ) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == DRAIN),
        .active(active),
        .done  (drain_done)
    );

`ifdef LANESWITCH_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q;
    logic          timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= (state_q == DRAIN) ? wd_q + WW'(1) : '0;
            // A simultaneous fault wins, so the cause is then not the watchdog.
            timeout_q <= timeout_q | (wd_expired && !fault);
        end
    end

    assign wd_expired = (state_q == DRAIN) && (wd_q == WW'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_q;
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Handshake: a lane owns the buffer while its grant is high; it releases
    // by holding done high for at least one cycle while granted. done from a
    // lane that is not granted is ignored, and a grant never returns until
    // the lane switch has drained and the select has flipped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OWN0:    if (lane0_done) state_d = DRAIN;
            OWN1:    if (lane1_done) state_d = DRAIN;
            DRAIN: begin
                if (wd_expired)      state_d = ERROR;
                else if (drain_done) state_d = FLIP;
            end
            FLIP:    state_d = SETTLE;
            SETTLE:  state_d = (switch == LS_LANE1) ? OWN1 : OWN0;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        if (fault) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= OWN0;
            switch      <= LS_LANE0;
            lane0_grant <= 1'b1;
            lane1_grant <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            swap_count  <= '0;
        end else begin
            state_q     <= state_d;
            lane0_grant <= (state_d == OWN0);
            lane1_grant <= (state_d == OWN1);
            busy        <= state_d inside {DRAIN, FLIP, SETTLE};
            error       <= (state_d == ERROR);
            if (state_q == FLIP && state_d == SETTLE) begin
                switch <= ~switch;
            end
            if (state_q == SETTLE && state_d != ERROR) begin
                swap_count <= swap_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_laneswitch_ctrl.sv
// Directed bench for laneswitch_ctrl: stimulus pushes expected output changes
// with their cycle into exp_q; the monitor pops one on every observed change.
module tb_laneswitch_ctrl;
    import laneswitch_pkg::*;

    localparam int DC = 2;
    localparam int TO = 8;
    localparam int CW = 2;
    localparam int OW = 6 + CW;
    localparam int EW = 32 + OW;
    localparam logic [31:0] ANY = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lane0_done = 1'b0;
    logic lane1_done = 1'b0;
    logic active = 1'b0;
    logic fault = 1'b0;
    logic switch, lane0_grant, lane1_grant, busy, error, timeout;
    logic [CW-1:0] swap_count;
    ls_state_t dbg_state;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];

    laneswitch_ctrl #(
        .DRAIN_CYCLES  (DC),
        .TIMEOUT_CYCLES(TO),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lane0_done (lane0_done),
        .lane1_done (lane1_done),
        .active     (active),
        .fault      (fault),
        .switch     (switch),
        .lane0_grant(lane0_grant),
        .lane1_grant(lane1_grant),
        .busy       (busy),
        .error      (error),
        .timeout    (timeout),
        .swap_count (swap_count),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle numbering: cycle n is the interval after rising edge n.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] ev(input int c, input logic sw, input logic g0,
                                         input logic g1, input logic bz, input logic er,
                                         input logic to, input logic [CW-1:0] cnt);
        logic [31:0] cu;
        cu = c;
        return {cu, sw, g0, g1, bz, er, to, cnt};
    endfunction

    // Driver tasks: called at a falling edge, return at a falling edge.
    task automatic handoff(input logic lane, input int act, input logic sw_before,
                           input logic [CW-1:0] cnt_before, input logic sw_after,
                           input logic [CW-1:0] cnt_after);
        int t;
        t = cyc;
        exp_q.push_back(ev(t + 1, sw_before, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt_before));
        exp_q.push_back(ev(t + DC + 2 + act, sw_after, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt_before));
        exp_q.push_back(ev(t + DC + 3 + act, sw_after, !sw_after, sw_after, 1'b0, 1'b0, 1'b0, cnt_after));
        if (lane) lane1_done = 1'b1;
        else      lane0_done = 1'b1;
        @(negedge clk);
        lane0_done = 1'b0;
        lane1_done = 1'b0;
        active = (act > 0);
        repeat (act) @(negedge clk);
        active = 1'b0;
        repeat (DC + 4) @(negedge clk);
    endtask

    task automatic pulse_ignored(input logic lane);
        if (lane) lane1_done = 1'b1;
        else      lane0_done = 1'b1;
        @(negedge clk);
        lane0_done = 1'b0;
        lane1_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic assert_reset(input int hold);
        exp_q.push_back(ev(cyc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        reset = 1'b0;
        repeat (hold) @(negedge clk);
        active = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard monitor: any change on the outputs must match the next entry.
    initial begin : monitor
        logic [OW-1:0] prev;
        logic [OW-1:0] obs;
        logic [EW-1:0] e;
        prev = 'x;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            obs = {switch, lane0_grant, lane1_grant, busy, error, timeout, swap_count};
            if (obs !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=unchanged %b",
                             cyc, obs, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e[OW-1:0] || (e[EW-1:OW] != ANY && e[EW-1:OW] != cyc)) begin
                        bad++;
                        $display("FAIL out_change cyc=%0d got=%b required=%b at_cyc=%0d",
                                 cyc, obs, e[OW-1:0], e[EW-1:OW]);
                    end
                end
                prev = obs;
            end
        end
    end

    initial begin : stimulus
        int t;
        exp_q.push_back(ev(ANY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        while (cyc < 10) @(negedge clk);

        // Basic handoff from cycle 10, then a foreign done while lane 1 owns.
        handoff(1'b0, 0, 1'b0, 2'd0, 1'b1, 2'd1);
        pulse_ignored(1'b0);
        // Drain stretched by three busy cycles, then ping-pong to a wrap.
        handoff(1'b1, 3, 1'b1, 2'd1, 1'b0, 2'd2);
        handoff(1'b0, 0, 1'b0, 2'd2, 1'b1, 2'd3);
        handoff(1'b1, 0, 1'b1, 2'd3, 1'b0, 2'd0);
        pulse_ignored(1'b1);

        // Reset arriving mid-drain with the select at lane 1.
        handoff(1'b0, 0, 1'b0, 2'd0, 1'b1, 2'd1);
        t = cyc;
        exp_q.push_back(ev(t + 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1));
        lane1_done = 1'b1;
        @(negedge clk);
        lane1_done = 1'b0;
        active = 1'b1;
        repeat (3) @(negedge clk);
        assert_reset(2);

        // Single-cycle fault while lane 1 owns; later dones must not move it.
        handoff(1'b0, 0, 1'b0, 2'd0, 1'b1, 2'd1);
        t = cyc;
        exp_q.push_back(ev(t + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        pulse_ignored(1'b1);
        pulse_ignored(1'b0);
        repeat (5) @(negedge clk);
        assert_reset(2);

        // Drain with the lane switch stuck busy.
        t = cyc;
        exp_q.push_back(ev(t + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
`ifdef LANESWITCH_CTRL_TIMEOUT_EN
        exp_q.push_back(ev(t + 1 + TO, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
`endif
        lane0_done = 1'b1;
        @(negedge clk);
        lane0_done = 1'b0;
        active = 1'b1;
`ifdef LANESWITCH_CTRL_TIMEOUT_EN
        repeat (TO + 6) @(negedge clk);
`else
        repeat (300) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
